rf_seq_ctrl: RTL and testbench

RF_SEQ_CTRL -- requirements
Module: rf_seq_ctrl

---
 rtl/rf_seq_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_rf_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rf_seq_ctrl
//
// Small sequencing controller that executes one command at a time against an
// external register file (RF) and an external 8-bit accumulator (ACC).
//
// The controller owns no data storage except a temporary byte T, which is
// used by the three-cycle SWAP and CLR sequences, and the Carry flag.
// Read data from the register file and the accumulator arrive asynchronously.
// Every write it requests takes effect at the next rising edge of CLK.
//
// Command opcodes:
//   000 NOP   Done only.
//   001 LDI   ACC <= imm.
//   010 LDR   ACC <= RF[reg].
//   011 STR   RF[reg] <= ACC.
//   100 SWAP  Exchange ACC and RF[reg] (3 cycles).
//   101 ADD   ACC <= ACC + RF[reg], Carry <= carry-out.
//             Only when RF_SEQ_ADD_EN is defined; otherwise reserved.
//   110 CLR   RF[reg] <= 0 via ACC, then ACC restored (3 cycles).
//   111 ---   Reserved; pulses Err.
//
// Configuration macro:
//   RF_SEQ_ADD_EN  If defined, enables the ADD opcode and the Carry flag.
//                  If undefined, op 101 is reserved and Carry is tied to 0.
//
// Parameters:
//   RAW  Register-file address width (2**RAW registers).
//   ACC  Register index that holds the accumulator.
//   SCR  Scratch register index. The design does not use it, but it must
//        differ from ACC.
//
// Ports:
//   CLK           Clock. All state changes on the rising edge.
//   Reset         Asynchronous reset, active high.
//   CmdValid      A command is offered.
//   CmdReady      The controller can accept a command (IDLE only).
//   CmdOp         Opcode (3 bits).
//   CmdReg        Register operand.
//   CmdImm        Immediate operand.
//   Done          One-cycle pulse in the final execute cycle of a command.
//   Err           One-cycle pulse for a reserved opcode.
//   Carry         Carry out of the last ADD.
//   ReadAddr      Register-file read address.
//   RegWriteAddr  Register-file write address.
//   ReadRegEn     1: read register contents; 0: address used as immediate.
//   WriteRegEn    RF[RegWriteAddr] <= ACC at the next edge.
//   WriteACCEn    ACC <= ACCWrite at the next edge.
//   ACCWrite      Accumulator write data.
//   ReadDataOut   Register-file read data (asynchronous).
//   ACCRead       Current accumulator value (asynchronous).
// ---------------------------------------------------------------------------
module rf_seq_ctrl #(
    parameter int             RAW = 4,
    parameter logic [RAW-1:0] ACC = 4'b1110,
    parameter logic [RAW-1:0] SCR = 4'b1101
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic           CmdValid,
    output logic           CmdReady,
    input  logic [2:0]     CmdOp,
    input  logic [RAW-1:0] CmdReg,
    input  logic [7:0]     CmdImm,
    output logic           Done,
    output logic           Err,
    output logic           Carry,
    output logic [RAW-1:0] ReadAddr,
    output logic [RAW-1:0] RegWriteAddr,
    output logic           ReadRegEn,
    output logic           WriteRegEn,
    output logic           WriteACCEn,
    output logic [7:0]     ACCWrite,
    input  logic [7:0]     ReadDataOut,
    input  logic [7:0]     ACCRead
);

    // The scratch index is only meaningful if it is not the accumulator.
    if (ACC == SCR) begin : gParamCheck
        $error("rf_seq_ctrl: SCR must differ from ACC");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        ST2  = 2'b10,
        ST3  = 2'b11
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_LDR  = 3'b010;
    localparam logic [2:0] OP_STR  = 3'b011;
    localparam logic [2:0] OP_SWAP = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    // Selects the source of ACCWrite. It is registered together with the
    // enables, so ACCWrite is 0 whenever the accumulator is not written.
    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_IMM  = 3'd1,
        SEL_RD   = 3'd2,
        SEL_SUM  = 3'd3,
        SEL_T    = 3'd4
    } accSel_t;

    typedef struct packed {
        logic    readRegEn;
        logic    writeRegEn;
        logic    writeAccEn;
        logic    done;
        logic    err;
        accSel_t accSel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{readRegEn: 1'b0, writeRegEn: 1'b0, writeAccEn: 1'b0,
                                    done: 1'b0, err: 1'b0, accSel: SEL_ZERO};
    // Second cycle of SWAP/CLR: store the accumulator into RF[reg].
    localparam ctrl_t CTRL_ST2  = '{readRegEn: 1'b0, writeRegEn: 1'b1, writeAccEn: 1'b0,
                                    done: 1'b0, err: 1'b0, accSel: SEL_ZERO};
    // Third cycle of SWAP/CLR: move T into the accumulator and finish.
    localparam ctrl_t CTRL_ST3  = '{readRegEn: 1'b0, writeRegEn: 1'b0, writeAccEn: 1'b1,
                                    done: 1'b1, err: 1'b0, accSel: SEL_T};

    // Control word for the first execute cycle of an opcode.
    function automatic ctrl_t execCtrl(input logic [2:0] op);
        ctrl_t c;
        c = CTRL_IDLE;
        case (op)
            OP_NOP: begin
                c.done = 1'b1;
            end
            OP_LDI: begin
                c.writeAccEn = 1'b1;
                c.accSel     = SEL_IMM;
                c.done       = 1'b1;
            end
            OP_LDR: begin
                c.readRegEn  = 1'b1;
                c.writeAccEn = 1'b1;
                c.accSel     = SEL_RD;
                c.done       = 1'b1;
            end
            OP_STR: begin
                c.writeRegEn = 1'b1;
                c.done       = 1'b1;
            end
            OP_SWAP: begin
                // Only reads here; T captures the register at the edge.
                c.readRegEn = 1'b1;
            end
            OP_ADD: begin
`ifdef RF_SEQ_ADD_EN
                c.readRegEn  = 1'b1;
                c.writeAccEn = 1'b1;
                c.accSel     = SEL_SUM;
                c.done       = 1'b1;
`else
                c.err = 1'b1;
`endif
            end
            OP_CLR: begin
                // T captures the accumulator while it is cleared.
                c.writeAccEn = 1'b1;
                c.accSel     = SEL_ZERO;
            end
            OP_RSV: begin
                c.err = 1'b1;
            end
            default: begin
                c.err = 1'b1;
            end
        endcase
        return c;
    endfunction

    // True for the opcodes that continue through ST2 and ST3.
    function automatic logic isMultiCycle(input logic [2:0] op);
        return (op == OP_SWAP) || (op == OP_CLR);
    endfunction

    state_t         state_r;
    logic           cmdReady_r;
    logic [2:0]     op_r;
    logic [RAW-1:0] reg_r;
    logic [7:0]     imm_r;
    logic [7:0]     t_r;
    ctrl_t          ctrl_r;
    logic [RAW-1:0] readAddr_r;
    logic [RAW-1:0] writeAddr_r;
    ctrl_t          acceptCtrl_s;

    assign acceptCtrl_s = execCtrl(CmdOp);

`ifdef RF_SEQ_ADD_EN
    logic       carry_r;
    logic [8:0] sum_s;

    assign sum_s = {1'b0, ACCRead} + {1'b0, ReadDataOut};
    assign Carry = carry_r;
`else
    assign Carry = 1'b0;
`endif

    // Main sequencer: state, latched command, T, Carry and the registered outputs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r     <= IDLE;
            cmdReady_r  <= 1'b1;
            op_r        <= 3'b000;
            reg_r       <= {RAW{1'b0}};
            imm_r       <= 8'h00;
            t_r         <= 8'h00;
            ctrl_r      <= CTRL_IDLE;
            readAddr_r  <= {RAW{1'b0}};
            writeAddr_r <= {RAW{1'b0}};
`ifdef RF_SEQ_ADD_EN
            carry_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (CmdValid) begin
                        state_r     <= EXEC;
                        cmdReady_r  <= 1'b0;
                        op_r        <= CmdOp;
                        reg_r       <= CmdReg;
                        imm_r       <= CmdImm;
                        ctrl_r      <= acceptCtrl_s;
                        readAddr_r  <= acceptCtrl_s.readRegEn  ? CmdReg : {RAW{1'b0}};
                        writeAddr_r <= acceptCtrl_s.writeRegEn ? CmdReg : {RAW{1'b0}};
                    end else begin
                        state_r     <= IDLE;
                        cmdReady_r  <= 1'b1;
                        ctrl_r      <= CTRL_IDLE;
                        readAddr_r  <= {RAW{1'b0}};
                        writeAddr_r <= {RAW{1'b0}};
                    end
                end
                EXEC: begin
                    // SWAP saves the register; CLR saves the accumulator before clearing it.
                    if (op_r == OP_SWAP) begin
                        t_r <= ReadDataOut;
                    end else if (op_r == OP_CLR) begin
                        t_r <= ACCRead;
                    end else begin
                        t_r <= t_r;
                    end
`ifdef RF_SEQ_ADD_EN
                    if (op_r == OP_ADD) begin
                        carry_r <= sum_s[8];
                    end else begin
                        carry_r <= carry_r;
                    end
`endif
                    if (isMultiCycle(op_r)) begin
                        state_r     <= ST2;
                        cmdReady_r  <= 1'b0;
                        ctrl_r      <= CTRL_ST2;
                        readAddr_r  <= {RAW{1'b0}};
                        writeAddr_r <= reg_r;
                    end else begin
                        state_r     <= IDLE;
                        cmdReady_r  <= 1'b1;
                        ctrl_r      <= CTRL_IDLE;
                        readAddr_r  <= {RAW{1'b0}};
                        writeAddr_r <= {RAW{1'b0}};
                    end
                end
                ST2: begin
                    state_r     <= ST3;
                    cmdReady_r  <= 1'b0;
                    ctrl_r      <= CTRL_ST3;
                    readAddr_r  <= {RAW{1'b0}};
                    writeAddr_r <= {RAW{1'b0}};
                end
                ST3: begin
                    state_r     <= IDLE;
                    cmdReady_r  <= 1'b1;
                    ctrl_r      <= CTRL_IDLE;
                    readAddr_r  <= {RAW{1'b0}};
                    writeAddr_r <= {RAW{1'b0}};
                end
                default: begin
                    state_r     <= IDLE;
                    cmdReady_r  <= 1'b1;
                    ctrl_r      <= CTRL_IDLE;
                    readAddr_r  <= {RAW{1'b0}};
                    writeAddr_r <= {RAW{1'b0}};
                end
            endcase
        end
    end

    assign CmdReady     = cmdReady_r;
    assign Done         = ctrl_r.done;
    assign Err          = ctrl_r.err;
    assign ReadRegEn    = ctrl_r.readRegEn;
    assign WriteRegEn   = ctrl_r.writeRegEn;
    assign WriteACCEn   = ctrl_r.writeAccEn;
    assign ReadAddr     = readAddr_r;
    assign RegWriteAddr = writeAddr_r;

    // Accumulator write data. The source is registered, but the data can be
    // the live register-file read, so this mux stays combinational.
    always_comb begin
        ACCWrite = 8'h00;
        case (ctrl_r.accSel)
            SEL_ZERO: ACCWrite = 8'h00;
            SEL_IMM:  ACCWrite = imm_r;
            SEL_RD:   ACCWrite = ReadDataOut;
`ifdef RF_SEQ_ADD_EN
            SEL_SUM:  ACCWrite = sum_s[7:0];
`else
            SEL_SUM:  ACCWrite = 8'h00;
`endif
            SEL_T:    ACCWrite = t_r;
            default:  ACCWrite = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_seq_ctrl
//
// Self-checking bench for rf_seq_ctrl. It models the register file, with the
// accumulator stored at index ACC. Directed commands push their hand-computed
// results into a scoreboard queue. A monitor pops one entry on each Done or
// Err pulse and checks the following:
//   - the pulse type and its latency;
//   - the accumulator, the selected register and Carry after the final write.
// ---------------------------------------------------------------------------
module tb_rf_seq_ctrl;

    localparam logic [3:0] ACC_IDX = 4'd14;
    localparam logic [3:0] SCR_IDX = 4'd13;

`ifdef RF_SEQ_ADD_EN
    localparam bit ADD_ON = 1'b1;
`else
    localparam bit ADD_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       Reset;
    logic       CmdValid;
    logic       CmdReady;
    logic [2:0] CmdOp;
    logic [3:0] CmdReg;
    logic [7:0] CmdImm;
    logic       Done, Err, Carry;
    logic [3:0] ReadAddr, RegWriteAddr;
    logic       ReadRegEn, WriteRegEn, WriteACCEn;
    logic [7:0] ACCWrite, ReadDataOut, ACCRead;

    rf_seq_ctrl #(.RAW(4), .ACC(4'b1110), .SCR(4'b1101)) dut (
        .CLK(CLK), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdReg(CmdReg), .CmdImm(CmdImm), .Done(Done), .Err(Err),
        .Carry(Carry), .ReadAddr(ReadAddr), .RegWriteAddr(RegWriteAddr),
        .ReadRegEn(ReadRegEn), .WriteRegEn(WriteRegEn), .WriteACCEn(WriteACCEn),
        .ACCWrite(ACCWrite), .ReadDataOut(ReadDataOut), .ACCRead(ACCRead)
    );

    always #5 CLK = ~CLK;

    // Register-file model; reset of the controller does not touch it.
    logic [7:0] rf [16];
    logic       rfClr;
    always @(posedge CLK) begin
        if (rfClr) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else begin
            if (WriteRegEn) rf[RegWriteAddr] <= rf[ACC_IDX];
            if (WriteACCEn) rf[ACC_IDX] <= ACCWrite;
        end
    end
    assign ReadDataOut = ReadRegEn ? rf[ReadAddr] : {4'b0000, ReadAddr};
    assign ACCRead     = rf[ACC_IDX];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int bothWe = 0;
    always @(negedge CLK) if (WriteRegEn && WriteACCEn) bothWe <= bothWe + 1;

    typedef struct packed {
        logic       err;
        int         lat;
        logic [7:0] acc;
        logic [3:0] ri;
        logic [7:0] rv;
        logic       cy;
        int         id;
        int         acceptCyc;
    } sb_t;

    sb_t sbQ[$];
    int  nChecks = 0;
    int  nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per Done/Err pulse.
    initial begin
        sb_t e;
        forever begin
            @(negedge CLK);
            if (!Reset && (Done || Err)) begin
                if (sbQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_pulse actual=Done%0b/Err%0b expected=none", Done, Err);
                end else begin
                    e = sbQ.pop_front();
                    check($sformatf("cmd%0d_err", e.id), {31'd0, Err}, {31'd0, e.err});
                    check($sformatf("cmd%0d_done", e.id), {31'd0, Done}, {31'd0, ~e.err});
                    check($sformatf("cmd%0d_latency", e.id), cyc - e.acceptCyc + 1, e.lat);
                    @(negedge CLK);
                    check($sformatf("cmd%0d_acc", e.id), {24'd0, rf[ACC_IDX]}, {24'd0, e.acc});
                    check($sformatf("cmd%0d_rf%0d", e.id, e.ri), {24'd0, rf[e.ri]}, {24'd0, e.rv});
                    check($sformatf("cmd%0d_carry", e.id), {31'd0, Carry}, {31'd0, e.cy});
                end
            end
        end
    end

    // Wait for ready, offer one command, and optionally schedule its expected result.
    task automatic issue(input int id, input logic [2:0] op, input logic [3:0] r,
                         input logic [7:0] imm, input logic err, input int lat,
                         input logic [7:0] acc, input logic [3:0] ri, input logic [7:0] rv,
                         input logic cy, input bit push);
        int n;
        sb_t e;
        n = 0;
        @(negedge CLK);
        while (!CmdReady && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!CmdReady) begin
            nChecks++;
            nFails++;
            $display("FAIL cmd%0d_ready_timeout actual=0 expected=1", id);
        end else begin
            CmdValid = 1'b1;
            CmdOp    = op;
            CmdReg   = r;
            CmdImm   = imm;
            @(posedge CLK);
            #1;
            CmdValid = 1'b0;
            if (push) begin
                e = '{err: err, lat: lat, acc: acc, ri: ri, rv: rv, cy: cy, id: id, acceptCyc: cyc};
                sbQ.push_back(e);
            end
        end
    endtask

    logic       addCy;
    logic       addErr;
    logic [7:0] addAcc;
    int         waitN;

    initial begin
        addCy  = ADD_ON ? 1'b1 : 1'b0;
        addErr = ADD_ON ? 1'b0 : 1'b1;
        addAcc = ADD_ON ? 8'h2C : 8'hC8;
        Reset = 1'b1; rfClr = 1'b1; CmdValid = 1'b0;
        CmdOp = 3'b000; CmdReg = 4'h0; CmdImm = 8'h00;
        repeat (3) @(negedge CLK);
        // Reset state.
        check("rst_ready", {31'd0, CmdReady}, 32'd1);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_err", {31'd0, Err}, 32'd0);
        check("rst_carry", {31'd0, Carry}, 32'd0);
        check("rst_ctrl", {24'd0, ReadAddr, RegWriteAddr}, 32'd0);
        check("rst_en", {29'd0, ReadRegEn, WriteRegEn, WriteACCEn}, 32'd0);
        check("rst_accwrite", {24'd0, ACCWrite}, 32'd0);
        Reset = 1'b0; rfClr = 1'b0;

        // Load/store/load round trip, then check the accept-to-ready spacing.
        issue(1, 3'b001, 4'd0, 8'h5A, 1'b0, 1, 8'h5A, 4'd3, 8'h00, 1'b0, 1'b1);
        @(negedge CLK);
        check("ldi_ready_exec", {31'd0, CmdReady}, 32'd0);
        @(negedge CLK);
        check("ldi_ready_back", {31'd0, CmdReady}, 32'd1);
        issue(2, 3'b011, 4'd3, 8'h00, 1'b0, 1, 8'h5A, 4'd3, 8'h5A, 1'b0, 1'b1);
        issue(3, 3'b010, 4'd3, 8'h00, 1'b0, 1, 8'h5A, 4'd3, 8'h5A, 1'b0, 1'b1);
        issue(4, 3'b001, 4'd0, 8'h00, 1'b0, 1, 8'h00, 4'd3, 8'h5A, 1'b0, 1'b1);
        issue(5, 3'b010, 4'd3, 8'h00, 1'b0, 1, 8'h5A, 4'd3, 8'h5A, 1'b0, 1'b1);
        issue(6, 3'b000, 4'd7, 8'hFF, 1'b0, 1, 8'h5A, 4'd7, 8'h00, 1'b0, 1'b1);

        // SWAP: ACC=F0, RF[2]=25.
        issue(7, 3'b001, 4'd0, 8'h25, 1'b0, 1, 8'h25, 4'd2, 8'h00, 1'b0, 1'b1);
        issue(8, 3'b011, 4'd2, 8'h00, 1'b0, 1, 8'h25, 4'd2, 8'h25, 1'b0, 1'b1);
        issue(9, 3'b001, 4'd0, 8'hF0, 1'b0, 1, 8'hF0, 4'd2, 8'h25, 1'b0, 1'b1);
        issue(10, 3'b100, 4'd2, 8'h00, 1'b0, 3, 8'h25, 4'd2, 8'hF0, 1'b0, 1'b1);

        // ADD: C8 + 64 = 0x12C.
        issue(11, 3'b001, 4'd0, 8'h64, 1'b0, 1, 8'h64, 4'd1, 8'h00, 1'b0, 1'b1);
        issue(12, 3'b011, 4'd1, 8'h00, 1'b0, 1, 8'h64, 4'd1, 8'h64, 1'b0, 1'b1);
        issue(13, 3'b001, 4'd0, 8'hC8, 1'b0, 1, 8'hC8, 4'd1, 8'h64, 1'b0, 1'b1);
        issue(14, 3'b101, 4'd1, 8'h00, addErr, 1, addAcc, 4'd1, 8'h64, addCy, 1'b1);

        // CLR on the scratch register; Carry must hold.
        issue(15, 3'b001, 4'd0, 8'h11, 1'b0, 1, 8'h11, SCR_IDX, 8'h00, addCy, 1'b1);
        issue(16, 3'b011, SCR_IDX, 8'h00, 1'b0, 1, 8'h11, SCR_IDX, 8'h11, addCy, 1'b1);
        issue(17, 3'b001, 4'd0, 8'h77, 1'b0, 1, 8'h77, SCR_IDX, 8'h11, addCy, 1'b1);
        issue(18, 3'b110, SCR_IDX, 8'h00, 1'b0, 3, 8'h77, SCR_IDX, 8'h00, addCy, 1'b1);

        // Reserved opcode; SWAP with the accumulator itself.
        issue(19, 3'b111, 4'd5, 8'hAA, 1'b1, 1, 8'h77, SCR_IDX, 8'h00, addCy, 1'b1);
        issue(20, 3'b100, ACC_IDX, 8'h00, 1'b0, 3, 8'h77, 4'd2, 8'hF0, addCy, 1'b1);

        // Reset during ST2 of SWAP: the ST2 store must not happen.
        issue(21, 3'b001, 4'd0, 8'h3C, 1'b0, 1, 8'h3C, 4'd2, 8'hF0, addCy, 1'b1);
        issue(22, 3'b100, 4'd2, 8'h00, 1'b0, 3, 8'h00, 4'd2, 8'h00, 1'b0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        check("abort_in_st2", {31'd0, WriteRegEn}, 32'd1);
        Reset = 1'b1;
        #1;
        check("abort_ready", {31'd0, CmdReady}, 32'd1);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_en", {29'd0, ReadRegEn, WriteRegEn, WriteACCEn}, 32'd0);
        check("abort_accwrite", {24'd0, ACCWrite}, 32'd0);
        check("abort_carry", {31'd0, Carry}, 32'd0);
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        check("abort_acc_kept", {24'd0, rf[ACC_IDX]}, 32'h3C);
        check("abort_rf2_kept", {24'd0, rf[2]}, 32'hF0);
        issue(23, 3'b001, 4'd0, 8'h81, 1'b0, 1, 8'h81, 4'd2, 8'hF0, 1'b0, 1'b1);

        waitN = 0;
        while (sbQ.size() != 0 && waitN < 50) begin
            @(negedge CLK);
            waitN++;
        end
        repeat (3) @(negedge CLK);
        check("scoreboard_drained", sbQ.size(), 32'd0);
        check("both_write_enables", bothWe, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
